pipeline_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage CPU pipeline: owns the PC, issues reads to the

---
 rtl/pipeline_fetch_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_pipeline_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_unit.sv
// ---------------------------------------------------------------------------
// pipeline_fetch_unit
//
// Instruction-fetch front end for the 5-stage pipeline. It owns the fetch PC,
// issues reads to the instruction cache and buffers fetched {PC, instruction}
// pairs in a DEPTH-entry circular prefetch FIFO. The FIFO feeds the ID stage
// through a valid/ready handshake. A taken branch or jump from EX (REDIRECT)
// flushes the FIFO and restarts fetch at the redirect target.
//
// Parameters
//   XLEN      width of PC and addresses
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  word-aligned PC loaded on reset
//
// Ports
//   CLK                 in   clock; all state updates on the rising edge
//   RESET               in   synchronous, active-low reset
//   ICACHE_ADDRESS      out  fetch PC presented to the instruction cache
//   ICACHE_READ         out  fetch request
//   ICACHE_INSTRUCTION  in   instruction word from the cache
//   ICACHE_BUSYWAIT     in   high = cache not ready; the word is valid when
//                            READ=1 and BUSYWAIT=0
//   REDIRECT            in   taken branch/jump from EX
//   REDIRECT_PC         in   redirect target (bits [1:0] are ignored)
//   ID_VALID            out  ID_INSTRUCTION / ID_PC are valid
//   ID_READY            in   ID stage accepts this cycle
//   ID_INSTRUCTION      out  instruction at the FIFO head
//   ID_PC               out  PC of that instruction
//   FIFO_COUNT          out  number of occupied FIFO entries
//
// Build option
//   FETCH_BYPASS_EN  When defined, a word accepted from the cache while the
//                    FIFO is empty is forwarded to ID_* in the same cycle. If
//                    ID_READY is high it is consumed without entering the
//                    FIFO; otherwise it is pushed as usual. When undefined,
//                    ID_* always come from the FIFO head (1-cycle latency).
// ---------------------------------------------------------------------------
module pipeline_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic                       CLK,
   input  logic                       RESET,
   output logic [XLEN-1:0]            ICACHE_ADDRESS,
   output logic                       ICACHE_READ,
   input  logic [31:0]                ICACHE_INSTRUCTION,
   input  logic                       ICACHE_BUSYWAIT,
   input  logic                       REDIRECT,
   input  logic [XLEN-1:0]            REDIRECT_PC,
   output logic                       ID_VALID,
   input  logic                       ID_READY,
   output logic [31:0]                ID_INSTRUCTION,
   output logic [XLEN-1:0]            ID_PC,
   output logic [$clog2(DEPTH+1)-1:0] FIFO_COUNT
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                run_q,      run_d;
   logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]       wr_ptr_q,   wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]       count_q,    count_d;
   logic [XLEN-1:0]     mem_pc_q    [DEPTH];
   logic [XLEN-1:0]     mem_pc_d    [DEPTH];
   logic [31:0]         mem_instr_q [DEPTH];
   logic [31:0]         mem_instr_d [DEPTH];
   // Last word presented on ID_*, so the outputs hold once the FIFO drains.
   logic [XLEN-1:0]     last_pc_q,    last_pc_d;
   logic [31:0]         last_instr_q, last_instr_d;

   // ------------------------------------------------------------------
   // Handshake terms
   // ------------------------------------------------------------------
   logic icache_read_s;
   logic accept_s;
   logic head_valid_s;
   logic fifo_valid_s;
   logic fifo_pop_s;
   logic bypass_s;
   logic bypass_take_s;
   logic push_s;
   logic unused_redirect_lsb_s;

   // The target is forced word aligned, so its two low bits are never used.
   assign unused_redirect_lsb_s = ^REDIRECT_PC[1:0];

   // Request, accept, pop and push qualifiers for this cycle.
   always_comb begin
      icache_read_s = run_q && (count_q < DEPTH_C);
      // A word returned while REDIRECT is high belongs to the wrong path.
      accept_s      = icache_read_s && !ICACHE_BUSYWAIT && !REDIRECT;
      head_valid_s  = (count_q != {CW{1'b0}});
      fifo_valid_s  = head_valid_s && !REDIRECT;
      fifo_pop_s    = fifo_valid_s && ID_READY;
`ifdef FETCH_BYPASS_EN
      bypass_s      = accept_s && !head_valid_s;
`else
      bypass_s      = 1'b0;
`endif
      bypass_take_s = bypass_s && ID_READY;
      // A bypassed word consumed by ID never occupies a FIFO slot.
      push_s        = accept_s && !bypass_take_s;
   end

   // Next-state computation for PC, FIFO storage, pointers and count.
   always_comb begin
      run_d        = 1'b1;
      fetch_pc_d   = fetch_pc_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      mem_pc_d     = mem_pc_q;
      mem_instr_d  = mem_instr_q;
      last_pc_d    = last_pc_q;
      last_instr_d = last_instr_q;

      if (REDIRECT) begin
         // Flush everything and restart at the aligned target.
         fetch_pc_d = {REDIRECT_PC[XLEN-1:2], 2'b00};
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_pc_d[wr_ptr_q]    = fetch_pc_q;
            mem_instr_d[wr_ptr_q] = ICACHE_INSTRUCTION;
            wr_ptr_d              = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (fifo_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         if (accept_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end

         case ({push_s, fifo_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end

      if (bypass_s) begin
         last_pc_d    = fetch_pc_q;
         last_instr_d = ICACHE_INSTRUCTION;
      end else if (head_valid_s) begin
         last_pc_d    = mem_pc_q[rd_ptr_q];
         last_instr_d = mem_instr_q[rd_ptr_q];
      end else begin
         last_pc_d    = last_pc_q;
         last_instr_d = last_instr_q;
      end
   end

   // State registers with synchronous active-low reset; reset beats REDIRECT.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         run_q        <= 1'b0;
         fetch_pc_q   <= RESET_PC;
         wr_ptr_q     <= {PW{1'b0}};
         rd_ptr_q     <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         last_pc_q    <= {XLEN{1'b0}};
         last_instr_q <= 32'h0000_0000;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]    <= {XLEN{1'b0}};
            mem_instr_q[i] <= 32'h0000_0000;
         end
      end else begin
         run_q        <= run_d;
         fetch_pc_q   <= fetch_pc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_pc_q    <= last_pc_d;
         last_instr_q <= last_instr_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]    <= mem_pc_d[i];
            mem_instr_q[i] <= mem_instr_d[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ICACHE_ADDRESS = fetch_pc_q;
   assign ICACHE_READ    = icache_read_s;
   assign FIFO_COUNT     = count_q;
   assign ID_VALID       = fifo_valid_s || bypass_s;

   // ID data: forwarded word, FIFO head, or the last word shown when empty.
   always_comb begin
      if (bypass_s) begin
         ID_PC          = fetch_pc_q;
         ID_INSTRUCTION = ICACHE_INSTRUCTION;
      end else if (head_valid_s) begin
         ID_PC          = mem_pc_q[rd_ptr_q];
         ID_INSTRUCTION = mem_instr_q[rd_ptr_q];
      end else begin
         ID_PC          = last_pc_q;
         ID_INSTRUCTION = last_instr_q;
      end
   end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// ---------------------------------------------------------------------------
// Testbench for pipeline_fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0x100).
// The cache returns (address ^ K) so every instruction is traceable to its PC.
// A queue-based model of the fetch buffer predicts all outputs every cycle;
// directed literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_pipeline_fetch_unit;

   localparam logic [31:0] K = 32'h5A5A_0000;
`ifdef FETCH_BYPASS_EN
   localparam logic [31:0] LAT4 = 32'd0;
`else
   localparam logic [31:0] LAT4 = 32'd4;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic        redir;
   logic        ready;
   logic [31:0] rpc;
   logic [31:0] icache_address;
   logic        icache_read;
   logic [31:0] icache_instruction;
   logic        id_valid;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic [2:0]  fifo_count;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   assign icache_instruction = icache_address ^ K;

   pipeline_fetch_unit #(
      .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0100)
   ) dut (
      .CLK(clk), .RESET(rst_n),
      .ICACHE_ADDRESS(icache_address), .ICACHE_READ(icache_read),
      .ICACHE_INSTRUCTION(icache_instruction), .ICACHE_BUSYWAIT(busy),
      .REDIRECT(redir), .REDIRECT_PC(rpc),
      .ID_VALID(id_valid), .ID_READY(ready),
      .ID_INSTRUCTION(id_instruction), .ID_PC(id_pc),
      .FIFO_COUNT(fifo_count)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_run = 1'b0;
   logic [31:0] m_pc  = 32'h100;
   logic [31:0] q_pc [$];

   function automatic bit m_read();
      return m_run && (q_pc.size() < 4);
   endfunction

   function automatic bit m_bypass();
`ifdef FETCH_BYPASS_EN
      return (q_pc.size() == 0) && m_read() && !busy && !redir;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_valid();
      return ((q_pc.size() != 0) && !redir) || m_bypass();
   endfunction

   function automatic logic [31:0] m_head();
      return m_bypass() ? m_pc : q_pc[0];
   endfunction

   always @(posedge clk) begin
      bit acc, pop, byp;
      if (!rst_n) begin
         m_run = 1'b0;
         m_pc  = 32'h100;
         q_pc.delete();
      end else begin
         acc = m_read() && !busy && !redir;
         pop = m_valid() && ready;
         byp = m_bypass();
         if (redir) begin
            q_pc.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
         end else begin
            if (pop && !byp) void'(q_pc.pop_front());
            if (acc && !(byp && pop)) q_pc.push_back(m_pc);
            if (acc) m_pc = m_pc + 32'd4;
         end
         m_run = 1'b1;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_read",  {31'd0, icache_read}, {31'd0, m_read()});
         check("m_addr",  icache_address, m_pc);
         check("m_valid", {31'd0, id_valid}, {31'd0, m_valid()});
         check("m_count", {29'd0, fifo_count}, 32'(q_pc.size()));
         if (m_valid()) begin
            check("m_id_pc",    id_pc, m_head());
            check("m_id_instr", id_instruction, m_head() ^ K);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input logic rdy);
      @(posedge clk); #1;
      rst_n = 1'b0; busy = 1'b0; redir = 1'b0; ready = rdy;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; busy = 1'b0; redir = 1'b0; ready = 1'b0; rpc = 32'h0;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // 1: reset values, idle cycle, then sequential addresses
      repeat (3) begin
         @(negedge clk);
         check("rst_read",  {31'd0, icache_read}, 32'd0);
         check("rst_valid", {31'd0, id_valid}, 32'd0);
         check("rst_count", {29'd0, fifo_count}, 32'd0);
         check("rst_addr",  icache_address, 32'h100);
         check("rst_id_pc", id_pc, 32'h0);
      end
      cyc(); rst_n = 1'b1; ready = 1'b1;
      @(negedge clk); check("idle_read", {31'd0, icache_read}, 32'd0);
      @(negedge clk); check("t1_addr0", icache_address, 32'h100);
                      check("t1_read",  {31'd0, icache_read}, 32'd1);
      // 2: streaming into ID
      @(negedge clk); check("t1_addr1", icache_address, 32'h104);
                      check("t2_pc0",   id_pc, 32'h104 - LAT4);
      @(negedge clk); check("t1_addr2", icache_address, 32'h108);
                      check("t2_pc1",   id_pc, 32'h108 - LAT4);
      @(negedge clk); check("t2_pc2",   id_pc, 32'h10C - LAT4);
                      check("t2_valid", {31'd0, id_valid}, 32'd1);

      // 3: fill to DEPTH, then drain in order
      do_reset(1'b0);
      repeat (5) cyc();
      @(negedge clk);
      check("t3_full",  {29'd0, fifo_count}, 32'd4);
      check("t3_read",  {31'd0, icache_read}, 32'd0);
      check("t3_addr",  icache_address, 32'h110);
      cyc(); ready = 1'b1;
      @(negedge clk); check("t3_head0", id_pc, 32'h100);
      @(negedge clk); check("t3_head1", id_pc, 32'h104);
                      check("t3_resume", icache_address, 32'h110);
      repeat (6) cyc();

      // 4: cache miss at 0x104
      do_reset(1'b0);
      cyc(); cyc(); busy = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_addr",  icache_address, 32'h104);
         check("t4_hold_count", {29'd0, fifo_count}, 32'd1);
      end
      cyc(); busy = 1'b0;
      @(negedge clk); check("t4_resume_read", {31'd0, icache_read}, 32'd1);
      @(negedge clk); check("t4_next_addr", icache_address, 32'h108);
                      check("t4_count2", {29'd0, fifo_count}, 32'd2);

      // 5: redirect with 3 entries while the cache is accepting
      do_reset(1'b0);
      cyc(); cyc(); cyc(); cyc();
      redir = 1'b1; rpc = 32'h203;
      @(negedge clk); check("t5_valid_redir", {31'd0, id_valid}, 32'd0);
                      check("t5_count3", {29'd0, fifo_count}, 32'd3);
      cyc(); redir = 1'b0; ready = 1'b1;
      @(negedge clk); check("t5_flushed", {29'd0, fifo_count}, 32'd0);
                      check("t5_target",  icache_address, 32'h200);
`ifdef FETCH_BYPASS_EN
                      check("t5_first_pc", id_pc, 32'h200);
`else
      @(negedge clk); check("t5_first_pc", id_pc, 32'h200);
`endif
      repeat (3) cyc();

      // 6: reset mid-miss with REDIRECT asserted
      do_reset(1'b1);
      cyc(); cyc(); busy = 1'b1;
      cyc(); redir = 1'b1; rpc = 32'h300; rst_n = 1'b0;
      cyc(); redir = 1'b0; busy = 1'b0; rst_n = 1'b1;
      @(negedge clk); check("t6_addr",  icache_address, 32'h100);
                      check("t6_count", {29'd0, fifo_count}, 32'd0);
                      check("t6_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_BYPASS_EN
      @(negedge clk); check("t6_byp_valid", {31'd0, id_valid}, 32'd1);
                      check("t6_byp_pc",    id_pc, 32'h100);
                      check("t6_byp_count", {29'd0, fifo_count}, 32'd0);
      @(negedge clk); check("t6_byp_count2", {29'd0, fifo_count}, 32'd0);
      cyc();
`else
      cyc(); cyc();
`endif
      // redirect during a miss: stale word never enqueued
      busy = 1'b1;
      cyc(); redir = 1'b1; rpc = 32'h40C;
      cyc(); redir = 1'b0;
      @(negedge clk); check("t6_miss_target", icache_address, 32'h40C);
                      check("t6_miss_count",  {29'd0, fifo_count}, 32'd0);
      cyc(); busy = 1'b0;
`ifndef FETCH_BYPASS_EN
      @(negedge clk);
`endif
      @(negedge clk); check("t6_miss_pc",    id_pc, 32'h40C);
                      check("t6_miss_instr", id_instruction, 32'h40C ^ K);

      // patterned traffic: pointer wrap, mixed stalls, one redirect
      for (int i = 0; i < 60; i++) begin
         cyc();
         ready = (i % 3) != 0;
         busy  = (i % 5) == 2;
         redir = (i == 37);
         rpc   = 32'hFFFF_FFF6;
      end
      cyc(); redir = 1'b0;
      repeat (8) cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
